// File: rtl/mux_2to1_arbiter.sv
// Two-requester arbiter driving a shared 2:1 data mux.
// Grants are mutually exclusive and appear one cycle after the request is
// sampled. Ties go to the requester not served last. A hold counter forces
// the owner to yield after MAX_HOLD cycles when the other side is waiting.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_a, req_b   requests for the shared mux
//   a, b           requester data (WIDTH bits)
//   gnt_a, gnt_b   registered grants
//   sel            registered mux select (0 = a, 1 = b), holds its value in idle
//   y              combinational mux output, sel ? b : a
//   valid          registered, gnt_a | gnt_b
module mux_2to1_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             valid
);

  localparam int unsigned CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_b_q, last_b_d;
  logic             gnt_a_q, gnt_a_d;
  logic             gnt_b_q, gnt_b_d;
  logic             sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             hold_expired;

  // State, counter, pointer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_b_q <= 1'b1;  // A wins the first tie
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      sel_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
    end
  end

  // Next state, hold counter and last-served pointer
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_b_d     = last_b_q;
    hold_expired = (cnt_q == HOLD_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (req_a && req_b)  state_d = last_b_q ? ST_GRANT_A : ST_GRANT_B;
        else if (req_a)      state_d = ST_GRANT_A;
        else if (req_b)      state_d = ST_GRANT_B;
      end
      ST_GRANT_A: begin
        // Yield when done, or when the hold budget is spent and B waits
        if (req_b && (hold_expired || !req_a)) state_d = ST_GRANT_B;
        else if (!req_a)                       state_d = ST_IDLE;
      end
      ST_GRANT_B: begin
        if (req_a && (hold_expired || !req_b)) state_d = ST_GRANT_A;
        else if (!req_b)                       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == ST_GRANT_A) last_b_d = 1'b0;
      if (state_d == ST_GRANT_B) last_b_d = 1'b1;
    end else if (state_q != ST_IDLE && !hold_expired) begin
      cnt_d = CNT_W'(cnt_q + 1'b1);
    end
  end

  // Registered outputs decoded from the next state
  always_comb begin
    gnt_a_d = (state_d == ST_GRANT_A);
    gnt_b_d = (state_d == ST_GRANT_B);
    valid_d = (state_d != ST_IDLE);
    sel_d   = sel_q;
    if (state_d == ST_GRANT_A) sel_d = 1'b0;
    if (state_d == ST_GRANT_B) sel_d = 1'b1;
  end

  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign y     = sel_q ? b : a;

endmodule

// File: tb/tb_mux_2to1_arbiter.sv
// Scoreboard bench for mux_2to1_arbiter: a behavioural model predicts the
// grant/sel/valid result of each cycle's inputs, queues it, and the queue is
// checked against the DUT after the following rising edge.
module tb_mux_2to1_arbiter;

  localparam int unsigned W    = 8;
  localparam int          MAXH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_a, req_b;
  logic [W-1:0] a, b;
  logic         gnt_a, gnt_b, sel, valid;
  logic [W-1:0] y;

  int total = 0;
  int bad   = 0;

  // model state: 0 idle, 1 grant A, 2 grant B
  int m_st;
  int m_cnt;
  bit m_last_b;
  bit m_sel;
  int wait_a, wait_b;
  logic [3:0] exp_q[$];  // {gnt_a, gnt_b, sel, valid}

  mux_2to1_arbiter #(.WIDTH(W), .MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req_a (req_a),
    .req_b (req_b),
    .a     (a),
    .b     (b),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b),
    .sel   (sel),
    .y     (y),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_next(int st, int cnt, bit lb, bit ra, bit rb);
    int nst;
    nst = st;
    case (st)
      0: begin
        if (ra && rb)  nst = lb ? 1 : 2;
        else if (ra)   nst = 1;
        else if (rb)   nst = 2;
      end
      1: begin
        if (rb && cnt == MAXH - 1) nst = 2;
        else if (!ra)              nst = rb ? 2 : 0;
      end
      2: begin
        if (ra && cnt == MAXH - 1) nst = 1;
        else if (!rb)              nst = ra ? 1 : 0;
      end
      default: nst = 0;
    endcase
    return nst;
  endfunction

  task automatic model_reset();
    m_st     = 0;
    m_cnt    = 0;
    m_last_b = 1'b1;
    m_sel    = 1'b0;
    wait_a   = 0;
    wait_b   = 0;
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus mid-cycle, predict, then check after the edge
  task automatic drive(input bit ra, input bit rb, input logic [W-1:0] da, input logic [W-1:0] db);
    int nst;
    logic [3:0] e;
    req_a = ra;
    req_b = rb;
    a     = da;
    b     = db;
    #1;
    chk("y_comb", 32'(y), 32'(m_sel ? db : da));

    nst = model_next(m_st, m_cnt, m_last_b, ra, rb);
    if (nst != m_st) begin
      m_cnt = 0;
      if (nst == 1) m_last_b = 1'b0;
      if (nst == 2) m_last_b = 1'b1;
    end else if (m_st != 0 && m_cnt < MAXH - 1) begin
      m_cnt++;
    end
    if (nst == 1) m_sel = 1'b0;
    if (nst == 2) m_sel = 1'b1;
    m_st = nst;
    exp_q.push_back({nst == 1, nst == 2, m_sel, nst != 0});

    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("gnt_a", 32'(gnt_a), 32'(e[3]));
      chk("gnt_b", 32'(gnt_b), 32'(e[2]));
      chk("sel",   32'(sel),   32'(e[1]));
      chk("valid", 32'(valid), 32'(e[0]));
    end
    chk("excl",  32'(gnt_a & gnt_b), 32'd0);
    chk("y_reg", 32'(y), 32'(m_sel ? db : da));

    if (ra && !gnt_a) wait_a++; else wait_a = 0;
    if (rb && !gnt_b) wait_b++; else wait_b = 0;
    chk("wait_a_bound", 32'(wait_a <= MAXH + 1), 32'd1);
    chk("wait_b_bound", 32'(wait_b <= MAXH + 1), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    a     = '0;
    b     = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt_a", 32'(gnt_a), 32'd0);
    chk("rst_gnt_b", 32'(gnt_b), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_sel",   32'(sel),   32'd0);

    // Release between edges with both requesting: A wins, y follows a
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'h3C, 8'hC3);
    chk("first_tie_y", 32'(y), 32'h3C);

    // Both held: A,A,A,A,B,B,B,B,A,... with no idle bubble
    for (int i = 0; i < 14; i++) drive(1'b1, 1'b1, 8'(i), 8'(8'hF0 + i));

    // Idle
    drive(1'b0, 1'b0, 8'h11, 8'h22);
    drive(1'b0, 1'b0, 8'h33, 8'h44);

    // A drops while B requests: direct handover
    drive(1'b1, 1'b0, 8'h55, 8'h66);
    drive(1'b1, 1'b0, 8'h57, 8'h68);
    drive(1'b0, 1'b1, 8'h59, 8'h6A);
    chk("handover_gnt_b", 32'(gnt_b), 32'd1);

    // B alone for 10 cycles: never preempted
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 8'(8'h80 + i), 8'(8'h90 + i));
    chk("b_hold_gnt_b", 32'(gnt_b), 32'd1);
    chk("b_hold_sel",   32'(sel),   32'd1);

    // Reset pulse between edges while in GRANT_B
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt_b", 32'(gnt_b), 32'd0);
    chk("midrst_gnt_a", 32'(gnt_a), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_sel",   32'(sel),   32'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
    drive(1'b1, 1'b1, 8'hA5, 8'h5A);
    chk("post_rst_gnt_a", 32'(gnt_a), 32'd1);

    // Random traffic, biased towards requesting to exercise preemption
    for (int i = 0; i < 1000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            8'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_2to1_arbiter.md
MUX_2TO1_ARBITER -- requirements
Module: mux_2to1_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of each requester path and of y.
REQ-002 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles while the other requester waits; legal range 2..255.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_a  input  1  requester A requests the shared mux.
REQ-006 req_b  input  1  requester B requests the shared mux.
REQ-007 a  input  WIDTH  requester A data.
REQ-008 b  input  WIDTH  requester B data.
REQ-009 gnt_a  output  1  A owns the mux.
REQ-010 gnt_b  output  1  B owns the mux.
REQ-011 sel  output  1  mux select: 0 selects a, 1 selects b.
REQ-012 y  output  WIDTH  mux output, combinational: sel ? b : a.
REQ-013 valid  output  1  gnt_a | gnt_b.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, GRANT_A and GRANT_B; gnt_a=1 only in GRANT_A, gnt_b=1 only in GRANT_B, and gnt_a and gnt_b are never both 1.
REQ-015 Grant latency SHALL be one cycle: a request sampled at edge N asserts the grant after edge N.
REQ-016 IDLE: req_a only -> GRANT_A; req_b only -> GRANT_B; both -> the requester not served last (last_b pointer); neither -> stay IDLE.
REQ-017 sel SHALL be a register: 0 in GRANT_A, 1 in GRANT_B, holding its last value in IDLE.
REQ-018 In GRANT_x with req_x deasserted at an edge: other requester asserted -> GRANT_other directly with no IDLE bubble; otherwise -> IDLE.
REQ-019 A hold counter SHALL clear on every state change and increment each cycle in a grant state, saturating at MAX_HOLD-1.
REQ-020 In GRANT_x with counter = MAX_HOLD-1 and the other requester asserted, the next state SHALL be GRANT_other regardless of req_x (forced preemption).
REQ-021 In GRANT_x with the other requester deasserted, the grant SHALL persist while req_x stays high, without limit.
REQ-022 The last-served pointer SHALL update on entry to GRANT_A (last = A) or GRANT_B (last = B).
REQ-023 A request dropping and the other request rising at the same edge SHALL be treated per REQ-018 (switch).
REQ-024 Changes to a and b SHALL propagate to y combinationally in the same cycle.

Reset
REQ-025 While rst_n=0: state IDLE, gnt_a=0, gnt_b=0, valid=0, sel=0, counter=0, last=B (A wins the first tie).
REQ-026 Reset asserted mid-grant SHALL force the REQ-025 values immediately, with no clock edge needed; the first edge after release evaluates per REQ-016.

Verification
REQ-027 Reset release with req_a=req_b=1 -> gnt_a=1, sel=0 after edge 1; y equals a (e.g. a=8'h3C, b=8'hC3 -> y=8'h3C).
REQ-028 req_b only for 10 cycles, req_a=0 -> gnt_b held all 10 cycles, sel=1, no preemption.
REQ-029 req_a and req_b both held high, MAX_HOLD=4 -> grants alternate A,A,A,A,B,B,B,B,A,... with no idle cycle.
REQ-030 GRANT_A, req_a drops while req_b=1 -> gnt_b=1 at the next edge; gnt_a and gnt_b never high together.
REQ-031 GRANT_B, rst_n pulsed low between edges -> gnt_b, valid and sel fall to 0 immediately.
REQ-032 Random req_a, req_b, a and b for 1000 cycles -> y always equals (sel ? b : a), and no requester waits more than MAX_HOLD+1 cycles.
